// File: rtl/ecc_fifo_reader_if.sv
// ecc_fifo_reader_if
//   Bundles the two buses of the ECC FIFO reader: the FIFO read port and the
//   downstream valid/ready output stream.
//   FIFO side : FifoEmpty_ (high = data present), FifoReadEn, FifoDataOut,
//               EccErr, EccUncorr (status of the word on FifoDataOut)
//   Stream    : M_Valid, M_Ready, M_Data, M_Err
//   Modports  : master = the reader block, slave = FIFO + downstream side.
interface ecc_fifo_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  FifoEmpty_;
  logic                  FifoReadEn;
  logic [DATA_WIDTH-1:0] FifoDataOut;
  logic                  EccErr;
  logic                  EccUncorr;
  logic                  M_Valid;
  logic                  M_Ready;
  logic [DATA_WIDTH-1:0] M_Data;
  logic                  M_Err;

  modport master (
    output FifoReadEn, M_Valid, M_Data, M_Err,
    input  FifoEmpty_, FifoDataOut, EccErr, EccUncorr, M_Ready
  );

  modport slave (
    input  FifoReadEn, M_Valid, M_Data, M_Err,
    output FifoEmpty_, FifoDataOut, EccErr, EccUncorr, M_Ready
  );
endinterface

// File: rtl/ecc_fifo_reader.sv
// ecc_fifo_reader
//   Read-side consumer of the ECC-protected FIFO. Issues read strobes,
//   captures each word with its ECC status the cycle after the strobe,
//   and forwards it through a 2-entry buffer on a valid/ready stream.
//   Counts corrected / uncorrectable events (saturating) and optionally
//   halts reading after an uncorrectable word.
// Ports:
//   Clock       : FIFO read clock, rising edge
//   Reset_      : asynchronous active-low reset
//   Enable      : level, permits new FIFO reads
//   ClearHalt   : pulse, HALT -> IDLE
//   ClearCounts : pulse, clears both counters
//   bus         : FIFO read port + output stream (master modport)
//   Halted      : high while in HALT
//   CorrCount   : corrected-error count
//   UncorrCount : uncorrectable-error count
module ecc_fifo_reader #(
  parameter int DATA_WIDTH     = 64,
  parameter int CNT_WIDTH      = 16,
  parameter bit STOP_ON_UNCORR = 1'b1
) (
  input  logic                 Clock,
  input  logic                 Reset_,
  input  logic                 Enable,
  input  logic                 ClearHalt,
  input  logic                 ClearCounts,
  ecc_fifo_reader_if.master    bus,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] CorrCount,
  output logic [CNT_WIDTH-1:0] UncorrCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [DATA_WIDTH:0]   r_buf [2];   // {uncorrectable flag, data}
  logic [CNT_WIDTH-1:0]  r_corr_cnt;
  logic [CNT_WIDTH-1:0]  r_unc_cnt;

  logic                  w_pop;
  logic                  w_cap;
  logic [2:0]            w_level;
  logic                  w_corr_evt;
  logic                  w_unc_evt;

  assign w_pop = (r_occ != 2'd0) & bus.M_Ready;
  assign w_cap = r_inflight;

  // Occupancy after this cycle's pop plus the word already in flight; a new
  // read is only issued if its data is guaranteed a free entry on arrival,
  // so captured data never needs back-pressure.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign bus.FifoReadEn = (r_state == S_RUN) & bus.FifoEmpty_ & (w_level < 3'd2);

  assign w_corr_evt = w_cap & bus.EccErr & ~bus.EccUncorr;
  assign w_unc_evt  = w_cap & bus.EccUncorr;

  // State register
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an uncorrectable capture outranks an Enable drop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (Enable) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_unc_evt && STOP_ON_UNCORR) w_state_nxt = S_HALT;
        else if (!Enable)                w_state_nxt = S_IDLE;
      end
      S_HALT: if (ClearHalt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // 2-entry output buffer; capture is unconditional whenever a read was
  // issued last cycle, independent of state.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= bus.FifoReadEn;
      if (w_cap) begin
        r_buf[r_wr_ptr] <= {bus.EccUncorr, bus.FifoDataOut};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_cap, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Saturating counters; a clear in the same cycle as an event yields 1.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
    end else begin
      if (ClearCounts) begin
        r_corr_cnt <= CNT_WIDTH'(w_corr_evt);
        r_unc_cnt  <= CNT_WIDTH'(w_unc_evt);
      end else begin
        if (w_corr_evt && (r_corr_cnt != '1)) r_corr_cnt <= r_corr_cnt + CNT_WIDTH'(1);
        if (w_unc_evt && (r_unc_cnt != '1))   r_unc_cnt  <= r_unc_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.M_Valid = (r_occ != 2'd0);
  assign bus.M_Data  = r_buf[r_rd_ptr][DATA_WIDTH-1:0];
  assign bus.M_Err   = r_buf[r_rd_ptr][DATA_WIDTH];
  assign Halted      = (r_state == S_HALT);
  assign CorrCount   = r_corr_cnt;
  assign UncorrCount = r_unc_cnt;

endmodule
